// File: rtl/alu_seq_unit_if.sv
// Decode-side instruction handshake and result handshake for alu_seq_unit.
// master = instruction source / result consumer, slave = the execution unit.
interface alu_seq_unit_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(WIDTH);

    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              instr_id;
    logic [AW-1:0]           rs;
    logic [AW-1:0]           rt;
    logic [AW-1:0]           rd;
    logic [15:0]             imm;
    logic [SW-1:0]           shamt;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] result;
    logic [AW-1:0]           wr_addr;
    logic                    illegal;
    logic                    ovf;

    modport master (
        output in_valid, instr_id, rs, rt, rd, imm, shamt, out_ready,
        input  in_ready, out_valid, result, wr_addr, illegal, ovf
    );

    modport slave (
        input  in_valid, instr_id, rs, rt, rd, imm, shamt, out_ready,
        output in_ready, out_valid, result, wr_addr, illegal, ovf
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU owning the register file and PC; shifts iterate one bit per cycle.
// Optional macro ALU_OVF_TRAP_EN: signed overflow on add/sub/addi suppresses the write and raises ovf.
module alu_seq_unit #(
    parameter int              WIDTH    = 32,
    parameter int              NREGS    = 32,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    alu_seq_unit_if.slave                 bus,
    output logic [PC_W-1:0]               pc,
    input  logic [$clog2(NREGS)-1:0]      dbg_addr,
    output logic signed [WIDTH-1:0]       dbg_data
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_ADDU  = 4'd3;
    localparam logic [3:0] OP_SUBU  = 4'd4;
    localparam logic [3:0] OP_ADDI  = 4'd5;
    localparam logic [3:0] OP_ADDIU = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_ANDI  = 4'd9;
    localparam logic [3:0] OP_ORI   = 4'd10;
    localparam logic [3:0] OP_SLL   = 4'd11;
    localparam logic [3:0] OP_SRL   = 4'd12;

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    state_t                  state_q, state_nx;
    logic [3:0]              instr_p0;
    logic [AW-1:0]           rd_p0;
    logic [15:0]             imm_p0;
    logic [SW-1:0]           shamt_p0;
    logic signed [WIDTH-1:0] op_a_p0, op_b_p0;
    logic signed [WIDTH-1:0] res_p1, res_nx, alu;
    logic [SW-1:0]           cnt_p1;
    logic                    ovf_p1, ovf_nx, ill_p1, ill_nx;
    logic                    commit, wr_en, is_shift;
    logic signed [WIDTH-1:0] regs [NREGS];

    function automatic logic signed [WIDTH-1:0] sext16(input logic [15:0] v);
        return WIDTH'(signed'(v));
    endfunction

    function automatic logic signed [WIDTH-1:0] zext16(input logic [15:0] v);
        return WIDTH'(v);
    endfunction

    function automatic logic signed [WIDTH-1:0] srl1(input logic signed [WIDTH-1:0] v);
        return signed'({1'b0, v[WIDTH-1:1]});
    endfunction

`ifdef ALU_OVF_TRAP_EN
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a, b, s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a, b, s);
        return (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction
`endif

    assign is_shift = (instr_p0 == OP_SLL) || (instr_p0 == OP_SRL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        res_nx   = res_p1;
        ovf_nx   = ovf_p1;
        ill_nx   = ill_p1;
        commit   = 1'b0;
        alu      = '0;
        case (state_q)
            IDLE: if (bus.in_valid) state_nx = EXEC;
            EXEC: begin
                ill_nx = 1'b0;
                ovf_nx = 1'b0;
                case (instr_p0)
                    OP_ADD, OP_ADDU:   alu = op_a_p0 + op_b_p0;
                    OP_SUB, OP_SUBU:   alu = op_a_p0 - op_b_p0;
                    OP_ADDI, OP_ADDIU: alu = op_a_p0 + sext16(imm_p0);
                    OP_AND:            alu = op_a_p0 & op_b_p0;
                    OP_OR:             alu = op_a_p0 | op_b_p0;
                    OP_ANDI:           alu = op_a_p0 & zext16(imm_p0);
                    OP_ORI:            alu = op_a_p0 | zext16(imm_p0);
                    OP_SLL, OP_SRL:    alu = op_a_p0;
                    default:           ill_nx = 1'b1;
                endcase
`ifdef ALU_OVF_TRAP_EN
                case (instr_p0)
                    OP_ADD:  ovf_nx = add_ovf(op_a_p0, op_b_p0, alu);
                    OP_SUB:  ovf_nx = sub_ovf(op_a_p0, op_b_p0, alu);
                    OP_ADDI: ovf_nx = add_ovf(op_a_p0, sext16(imm_p0), alu);
                    default: ovf_nx = 1'b0;
                endcase
`endif
                res_nx = alu;
                if (is_shift && (shamt_p0 != '0)) begin
                    state_nx = SHIFT;
                end else begin
                    state_nx = DONE;
                    commit   = 1'b1;
                end
            end
            SHIFT: begin
                res_nx = (instr_p0 == OP_SLL) ? (res_p1 <<< 1) : srl1(res_p1);
                // the last single-bit step lands directly in DONE with the final value
                if (cnt_p1 == SW'(1)) begin
                    state_nx = DONE;
                    commit   = 1'b1;
                end
            end
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign wr_en = commit && !ill_nx && !ovf_nx && (rd_p0 != '0);

    // Stage p0: operand capture at accept; stage p1: result, flags, shift count, writeback
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_p0 <= '0;
            rd_p0    <= '0;
            imm_p0   <= '0;
            shamt_p0 <= '0;
            op_a_p0  <= '0;
            op_b_p0  <= '0;
            res_p1   <= '0;
            cnt_p1   <= '0;
            ovf_p1   <= 1'b0;
            ill_p1   <= 1'b0;
            pc       <= RESET_PC;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (state_q == IDLE && bus.in_valid) begin
                instr_p0 <= bus.instr_id;
                rd_p0    <= bus.rd;
                imm_p0   <= bus.imm;
                shamt_p0 <= bus.shamt;
                op_a_p0  <= regs[bus.rs];
                op_b_p0  <= regs[bus.rt];
            end
            if (state_q == EXEC)       cnt_p1 <= shamt_p0;
            else if (state_q == SHIFT) cnt_p1 <= cnt_p1 - SW'(1);
            res_p1 <= res_nx;
            ovf_p1 <= ovf_nx;
            ill_p1 <= ill_nx;
            if (commit) pc <= pc + PC_W'(4);
            if (wr_en)  regs[rd_p0] <= res_nx;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_p1;
    assign bus.wr_addr   = rd_p0;
    assign bus.illegal   = ill_p1;
`ifdef ALU_OVF_TRAP_EN
    assign bus.ovf       = ovf_p1;
`else
    assign bus.ovf       = 1'b0;
`endif
    assign dbg_data      = regs[dbg_addr];
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: the driver queues expected results, a negedge monitor checks them.
module tb_alu_seq_unit;
    typedef struct {
        logic [31:0] res;
        int          wa;
        bit          ill;
        bit          ov;
        int          lat;
    } exp_t;

`ifdef ALU_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   epc = 0;
    bit   seen = 0;
    int   first_cyc = 0;

    alu_seq_unit_if #(.WIDTH(32), .NREGS(32)) bus ();

    alu_seq_unit #(.WIDTH(32), .NREGS(32), .PC_W(32), .RESET_PC(32'h0)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .pc       (pc),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: records accept cycles and checks every completed result against the queue
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (reset) begin
            seen = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
            if (bus.out_valid) begin
                if (!seen) begin
                    seen      = 1'b1;
                    first_cyc = cyc + 1;
                end
                if (bus.out_ready) begin
                    seen = 1'b0;
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: result %h with no instruction pending", bus.result);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        chk("result",  bus.result, e.res);
                        chk("wr_addr", 32'(bus.wr_addr), 32'(e.wa));
                        chk("illegal", 32'(bus.illegal), 32'(e.ill));
                        chk("ovf",     32'(bus.ovf), 32'(e.ov));
                        chk("latency", 32'(first_cyc - a), 32'(e.lat));
                    end
                end
            end
        end
    end

    task automatic issue(input logic [3:0] id, input int rs_, input int rt_, input int rd_,
                         input logic [15:0] im, input int sh, input logic [31:0] er,
                         input bit eill, input bit eov, input int elat, input bit push,
                         output int acc);
        exp_t e;
        @(posedge clk);
        #1;
        bus.instr_id = id;
        bus.rs       = 5'(rs_);
        bus.rt       = 5'(rt_);
        bus.rd       = 5'(rd_);
        bus.imm      = im;
        bus.shamt    = 5'(sh);
        bus.in_valid = 1'b1;
        if (push) begin
            e.res = er; e.wa = rd_; e.ill = eill; e.ov = eov; e.lat = elat;
            exp_q.push_back(e);
        end
        acc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        if (acc < 0) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: instr %0d not accepted, required within 100 cycles", id);
        end else begin
            epc += 4;
        end
    endtask

    task automatic op(input logic [3:0] id, input int rs_, input int rt_, input int rd_,
                      input logic [15:0] im, input int sh, input logic [31:0] er,
                      input bit eill, input bit eov, input int elat);
        int acc;
        issue(id, rs_, rt_, rd_, im, sh, er, eill, eov, elat, 1'b1, acc);
    endtask

    task automatic wait_idle();
        bit ok;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: in_ready 0 after 200 cycles, required 1");
        end
    endtask

    task automatic chk_reg(input int addr, input logic [31:0] exp, input string nm);
        dbg_addr = 5'(addr);
        #1;
        chk(nm, dbg_data, exp);
    endtask

    initial begin
        int acc_a, acc_b, nz;
        bit got;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.instr_id = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.imm = '0; bus.shamt = '0;
        dbg_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result",    bus.result, 32'd0);
        chk("rst_wr_addr",   32'(bus.wr_addr), 32'd0);
        chk("rst_flags",     {30'd0, bus.illegal, bus.ovf}, 32'd0);
        chk("rst_pc",        pc, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);

        op(4'd5, 0, 0, 1, 16'd5, 0, 32'd5, 0, 0, 2);
        op(4'd5, 0, 0, 2, 16'd7, 0, 32'd7, 0, 0, 2);
        op(4'd1, 1, 2, 3, 16'd0, 0, 32'd12, 0, 0, 2);
        wait_idle();
        chk_reg(3, 32'd12, "dbg_r3_add");
        chk("pc_after_3", pc, 32'd12);

        op(4'd5, 0, 0, 4, 16'hFFFF, 0, 32'hFFFF_FFFF, 0, 0, 2);
        op(4'd9, 4, 0, 5, 16'hFFFF, 0, 32'h0000_FFFF, 0, 0, 2);
        wait_idle();
        chk_reg(4, 32'hFFFF_FFFF, "dbg_r4_addi_sext");
        chk_reg(5, 32'h0000_FFFF, "dbg_r5_andi_zext");

        issue(4'd11, 4, 9, 6, 16'd0, 4, 32'hFFFF_FFF0, 0, 0, 6, 1'b1, acc_a);
        issue(4'd12, 5, 9, 7, 16'd0, 0, 32'h0000_FFFF, 0, 0, 2, 1'b1, acc_b);
        chk("accept_gap_sll4", 32'(acc_b - acc_a), 32'd7);
        op(4'd12, 4, 0, 8, 16'd0, 8, 32'h00FF_FFFF, 0, 0, 10);
        op(4'd2, 1, 2, 9, 16'd0, 0, 32'hFFFF_FFFE, 0, 0, 2);
        op(4'd8, 1, 2, 10, 16'd0, 0, 32'd7, 0, 0, 2);
        op(4'd10, 1, 0, 11, 16'h8000, 0, 32'h0000_8005, 0, 0, 2);
        op(4'd7, 5, 2, 12, 16'd0, 0, 32'd7, 0, 0, 2);
        op(4'd4, 2, 1, 13, 16'd0, 0, 32'd2, 0, 0, 2);
        op(4'd6, 1, 0, 14, 16'hFFFF, 0, 32'd4, 0, 0, 2);
        wait_idle();
        chk_reg(6, 32'hFFFF_FFF0, "dbg_r6_sll");
        chk_reg(8, 32'h00FF_FFFF, "dbg_r8_srl");
        chk("pc_after_14", pc, 32'(epc));

        // Back-pressure: result must hold while out_ready stays low
        @(posedge clk); #1 bus.out_ready = 1'b0;
        op(4'd3, 1, 2, 15, 16'd0, 0, 32'd12, 0, 0, 2);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin got = 1'b1; break; end
        end
        chk("hold_out_valid_seen", 32'(got), 32'd1);
        chk("hold_pc_commit", pc, 32'(epc));
        repeat (5) begin
            @(negedge clk);
            chk("hold_result",    bus.result, 32'd12);
            chk("hold_in_ready",  32'(bus.in_ready), 32'd0);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_pc",        pc, 32'(epc));
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;

        op(4'd12, 4, 0, 16, 16'd0, 1, 32'h7FFF_FFFF, 0, 0, 3);
        op(4'd5, 0, 0, 17, 16'd1, 0, 32'd1, 0, 0, 2);
        op(4'd1, 16, 17, 18, 16'd0, 0, 32'h8000_0000, 0, TRAP, 2);
        op(4'd3, 16, 17, 19, 16'd0, 0, 32'h8000_0000, 0, 0, 2);
        op(4'd5, 16, 0, 20, 16'd1, 0, 32'h8000_0000, 0, TRAP, 2);
        op(4'd14, 1, 2, 21, 16'd0, 0, 32'd0, 1, 0, 2);
        op(4'd0, 1, 2, 22, 16'd0, 0, 32'd0, 1, 0, 2);
        op(4'd5, 0, 0, 0, 16'd5, 0, 32'd5, 0, 0, 2);
        wait_idle();
        chk_reg(18, TRAP ? 32'd0 : 32'h8000_0000, "dbg_r18_add_ovf");
        chk_reg(19, 32'h8000_0000, "dbg_r19_addu");
        chk_reg(20, TRAP ? 32'd0 : 32'h8000_0000, "dbg_r20_addi_ovf");
        chk_reg(21, 32'd0, "dbg_r21_illegal");
        chk_reg(22, 32'd0, "dbg_r22_illegal0");
        chk_reg(0, 32'd0, "dbg_r0_write");
        chk("pc_before_reset", pc, 32'(epc));

        // Reset three cycles into a 20-bit shift
        issue(4'd11, 1, 0, 23, 16'd0, 20, 32'd0, 0, 0, 0, 1'b0, acc_a);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        acc_q.delete();
        epc = 0;
        #1;
        chk("midshift_rst_pc",        pc, 32'd0);
        chk("midshift_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midshift_rst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("midshift_rst_result",    bus.result, 32'd0);
        nz = 0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            if (dbg_data != 32'd0) nz++;
        end
        chk("midshift_rst_regs_nonzero", 32'(nz), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (30) @(negedge clk);
        op(4'd5, 0, 0, 1, 16'd9, 0, 32'd9, 0, 0, 2);
        wait_idle();
        chk_reg(1, 32'd9, "dbg_r1_after_reset");
        chk("pc_after_reset_op", pc, 32'd4);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
